// File: rtl/svc_rv_uart_pkg.sv
// Shared constants and types for the MMIO UART transmitter: register map,
// STATUS bit positions, serializer states and the divisor type.
package svc_rv_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    typedef logic [15:0] div_t;

endpackage

// File: rtl/svc_rv_uart_tx_fifo.sv
// Transmit byte queue. SVC_RV_UART_TX_FIFO_EN selects a 2^DEPTH_LOG2 FIFO;
// otherwise a single holding register (full == valid).
module svc_rv_uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);

    logic w_push;
    logic w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

`ifdef SVC_RV_UART_TX_FIFO_EN
    localparam int                  DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;

    // Storage is not reset; contents are meaningless until the count says so.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == L_FULL);
    assign o_empty = (r_count == '0);
`else
    logic        r_valid;
    logic [7:0]  r_data;
    logic [31:0] w_unused_depth;

    assign w_unused_depth = 32'(DEPTH_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_push) begin
                r_valid <= 1'b1;
                r_data  <= i_din;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_dout  = r_data;
    assign o_full  = r_valid;
    assign o_empty = ~r_valid;
`endif

endmodule

// File: rtl/svc_rv_mmio_uart_tx.sv
// MMIO 8N1 UART transmitter: register decode, read mux, overflow flag and
// serializer FSM. SVC_RV_UART_TX_FIFO_EN enables the deep transmit FIFO.
module svc_rv_mmio_uart_tx
    import svc_rv_uart_pkg::*;
#(
    parameter int DEPTH_LOG2  = 3,
    parameter int DEFAULT_DIV = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic        txd,
    output logic        tx_idle
);

    tx_state_e   r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    div_t        r_baud, w_baud_nxt;
    logic [2:0]  r_bitcnt, w_bitcnt_nxt;
    div_t        r_div;
    logic        r_ovf;
    logic        r_txd;
    logic [31:0] r_rd_data;

    logic        w_wr_tx, w_clr_ovf, w_wr_div;
    logic        w_pop, w_full, w_empty;
    logic [7:0]  w_fifo_dout;
    logic [31:0] w_status, w_rd_mux;
    logic        w_unused;

    assign w_unused = &{1'b0, rd_addr[31:4], rd_addr[1:0], wr_addr[31:4],
                        wr_addr[1:0], wr_data[31:16], wr_strb[3:2]};

    assign w_wr_tx   = wr_en && (wr_addr[3:2] == REG_TXDATA) && wr_strb[0];
    assign w_clr_ovf = wr_en && (wr_addr[3:2] == REG_STATUS) && wr_strb[0] && wr_data[3];
    assign w_wr_div  = wr_en && (wr_addr[3:2] == REG_DIVISOR);

    svc_rv_uart_tx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_wr_tx),
        .i_din  (wr_data[7:0]),
        .i_pop  (w_pop),
        .o_dout (w_fifo_dout),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= div_t'(DEFAULT_DIV);
            r_ovf <= 1'b0;
        end else begin
            if (w_wr_div && wr_strb[0]) r_div[7:0]  <= wr_data[7:0];
            if (w_wr_div && wr_strb[1]) r_div[15:8] <= wr_data[15:8];
            // A dropped push wins over a clear; both cannot arrive in one cycle anyway.
            if (w_wr_tx && w_full) r_ovf <= 1'b1;
            else if (w_clr_ovf)    r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_status           = '0;
        w_status[ST_BUSY]  = (r_state != S_IDLE);
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_OVF]   = r_ovf;
        case (rd_addr[3:2])
            REG_STATUS:  w_rd_mux = w_status;
            REG_DIVISOR: w_rd_mux = {16'h0, r_div};
            default:     w_rd_mux = '0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_baud_nxt   = r_baud;
        w_bitcnt_nxt = r_bitcnt;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_baud_nxt  = r_div;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_baud == '0) begin
                    w_state_nxt  = S_DATA;
                    w_baud_nxt   = r_div;
                    w_bitcnt_nxt = '0;
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end
            S_DATA: begin
                if (r_baud == '0) begin
                    w_baud_nxt   = r_div;
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_nxt = S_STOP;
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end
            S_STOP: begin
                if (r_baud == '0) begin
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_baud_nxt  = r_div;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bitcnt  <= '0;
            r_txd     <= 1'b1;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_baud    <= w_baud_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_txd     <= (w_state_nxt == S_START) ? 1'b0 :
                         (w_state_nxt == S_DATA)  ? w_shift_nxt[0] : 1'b1;
            r_rd_data <= w_rd_mux;
        end
    end

    assign txd     = r_txd;
    assign tx_idle = w_empty && (r_state == S_IDLE);
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_svc_rv_mmio_uart_tx.sv
// Directed bench for svc_rv_mmio_uart_tx: register access, frame timing,
// back-to-back frames, overflow, async reset and divisor byte lanes.
module tb_svc_rv_mmio_uart_tx;

    localparam logic [31:0] A_TX  = 32'h0;
    localparam logic [31:0] A_ST  = 32'h4;
    localparam logic [31:0] A_DIV = 32'h8;
    localparam logic [31:0] A_RSV = 32'hC;
`ifdef SVC_RV_UART_TX_FIFO_EN
    localparam int FILL_PUSHES = 9;
`else
    localparam int FILL_PUSHES = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        txd;
    logic        tx_idle;

    int checks   = 0;
    int failures = 0;

    svc_rv_mmio_uart_tx #(
        .DEPTH_LOG2 (3),
        .DEFAULT_DIV(15)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .txd    (txd),
        .tx_idle(tx_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_strb = s;
        tick();
        wr_en   = 1'b0;
        wr_strb = '0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd_addr = a;
        tick();
        check(tag, rd_data, exp);
    endtask

    logic [9:0]  bits_a5;
    logic [19:0] bits_b2b;
    int          low_cnt;

    initial begin
        bits_a5  = 10'b11_1010_0101 << 1 | 10'b0;
        bits_a5  = 10'b1101001010;
        bits_b2b = 20'h81202;

        // Reset state
        repeat (3) tick();
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_txd", {31'h0, txd}, 32'h1);
        rst = 1'b0;
        rd_check("rst_status", A_ST, 32'h4);
        check("rst_tx_idle", {31'h0, tx_idle}, 32'h1);

        // DIVISOR=3, one 0xA5 frame sampled mid-bit
        wr(A_DIV, 32'h3, 4'b0011);
        wr(A_TX, 32'hA5, 4'b0001);
        check("a5_txd_pre", {31'h0, txd}, 32'h1);
        check("a5_busy_idle", {31'h0, tx_idle}, 32'h0);
        tick();
        check("a5_start_fall", {31'h0, txd}, 32'h0);
        tick(); tick();
        check("a5_bit0", {31'h0, txd}, {31'h0, bits_a5[0]});
        for (int k = 1; k < 10; k++) begin
            repeat (4) tick();
            check($sformatf("a5_bit%0d", k), {31'h0, txd}, {31'h0, bits_a5[k]});
        end
        tick();
        check("a5_idle_n40", {31'h0, tx_idle}, 32'h0);
        tick();
        check("a5_idle_n41", {31'h0, tx_idle}, 32'h1);

        // DIVISOR=0, two frames with no gap
        wr(A_DIV, 32'h0, 4'b0011);
        wr_en = 1'b1; wr_addr = A_TX; wr_data = 32'h01; wr_strb = 4'b0001;
        tick();
        wr_en = 1'b0;
        tick();
        check("b2b_bit0", {31'h0, txd}, {31'h0, bits_b2b[0]});
        wr_en = 1'b1; wr_data = 32'h02;
        tick();
        wr_en = 1'b0;
        check("b2b_bit1", {31'h0, txd}, {31'h0, bits_b2b[1]});
        for (int i = 2; i < 20; i++) begin
            tick();
            check($sformatf("b2b_bit%0d", i), {31'h0, txd}, {31'h0, bits_b2b[i]});
        end
        tick();
        check("b2b_idle", {31'h0, tx_idle}, 32'h1);

        // Divisor byte lanes, aliasing, reserved reads
        wr(A_DIV, 32'h1234, 4'b0011);
        wr(A_DIV, 32'h0007, 4'b0010);
        rd_check("div_lane1", 32'h18, 32'h0034);
        rd_check("txdata_rd0", A_TX, 32'h0);
        rd_check("rsvd_rd0", A_RSV, 32'h0);

        // Fill and overflow at a very slow bit rate
        wr(A_DIV, 32'hFFFF, 4'b0011);
        wr(A_TX, 32'h55, 4'b0001);
        tick();
        for (int i = 0; i < FILL_PUSHES; i++) wr(A_TX, 32'h10 + i, 4'b0001);
        rd_check("ovf_status", A_ST, 32'hB);
        wr(A_ST, 32'h8, 4'b0001);
        rd_check("ovf_cleared", A_ST, 32'h3);

        // Reset during data bits
        rst = 1'b1; tick(); rst = 1'b0;
        wr(A_DIV, 32'h3, 4'b0011);
        wr(A_TX, 32'h00, 4'b0001);
        tick();
        wr(A_TX, 32'hFF, 4'b0001);
        repeat (6) tick();
        check("mid_data_low", {31'h0, txd}, 32'h0);
        rst = 1'b1;
        #1;
        check("async_txd", {31'h0, txd}, 32'h1);
        check("async_idle", {31'h0, tx_idle}, 32'h1);
        rst = 1'b0;
        rd_check("post_rst_status", A_ST, 32'h4);
        low_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (txd !== 1'b1) low_cnt++;
        end
        check("no_frame_after_rst", low_cnt, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
